// File: rtl/nios_nios2_gen2_0_cpu_debug_mem_engine.sv
// rtl/nios_nios2_gen2_0_cpu_debug_mem_engine.sv - debug command to Avalon-MM single-word engine (optional NIOS_DBG_MEM_TIMEOUT_EN)
module nios_nios2_gen2_0_cpu_debug_mem_engine #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic              auto_inc;
  logic              any_cmd;
  logic [ADDR_W-1:0] done_addr;
  logic              tmo_hit;

  // Only the bits that carry address, flags or write data are meaningful
  logic unused_jdo;
  assign unused_jdo = ^jdo[37:36];

  assign any_cmd     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign avm_address = {word_addr, 2'b00};
  assign done_addr   = auto_inc ? word_addr + ADDR_W'(1) : word_addr;

`ifdef NIOS_DBG_MEM_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] tmo_cnt;

  // The last busy cycle of the budget aborts the access on its closing edge
  assign tmo_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign tmo_hit = 1'b0;
`endif

  // Command decode, bus sequencing and status reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      word_addr     <= '0;
      auto_inc      <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      // A command while busy is dropped but remembered as an error
      if (state != IDLE && any_cmd) begin
        monitor_error <= 1'b1;
      end
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
      tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + 1'b1;
`endif
      if (tmo_hit) begin
        state         <= IDLE;
        avm_read      <= 1'b0;
        avm_write     <= 1'b0;
        MonDReg       <= 32'hDEADDEAD;
        monitor_ready <= 1'b1;
        monitor_error <= 1'b1;
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
        tmo_cnt       <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (take_action_ocimem_b) begin
              avm_writedata <= jdo[34:3];
              avm_write     <= 1'b1;
              monitor_ready <= 1'b0;
              state         <= WR_REQ;
            end else if (take_action_ocimem_a) begin
              word_addr     <= jdo[ADDR_W-1:0];
              auto_inc      <= jdo[34];
              monitor_error <= 1'b0;
              if (jdo[35]) begin
                avm_read      <= 1'b1;
                monitor_ready <= 1'b0;
                state         <= RD_REQ;
              end
            end else if (take_no_action_ocimem_a) begin
              avm_read      <= 1'b1;
              monitor_ready <= 1'b0;
              state         <= RD_REQ;
            end
          end
          RD_REQ: begin
            if (!avm_waitrequest) begin
              avm_read <= 1'b0;
              state    <= RD_WAIT;
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end
          end
          RD_WAIT: begin
            if (avm_readdatavalid) begin
              MonDReg       <= avm_readdata;
              monitor_ready <= 1'b1;
              word_addr     <= done_addr;
              state         <= IDLE;
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end
          end
          WR_REQ: begin
            if (!avm_waitrequest) begin
              avm_write     <= 1'b0;
              monitor_ready <= 1'b1;
              word_addr     <= done_addr;
              state         <= IDLE;
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_nios2_gen2_0_cpu_debug_mem_engine.sv
// tb/tb_nios_nios2_gen2_0_cpu_debug_mem_engine.sv - randomized self-checking bench with transaction-level model
module tb_nios_nios2_gen2_0_cpu_debug_mem_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [17:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  nios_nios2_gen2_0_cpu_debug_mem_engine #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_waitrequest         (avm_waitrequest),
    .avm_readdata            (avm_readdata),
    .avm_readdatavalid       (avm_readdatavalid),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  int tests = 0;
  int fails = 0;

  // Transaction-level model of the engine and a word memory behind the bus
  logic [31:0] mem [int];
  logic [15:0] m_addr = '0;
  bit          m_inc = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_mon = '0;
  logic [31:0] m_wdata = '0;
  int          last_lat = 0;
  int          last_hi = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(int'(a))) mem[int'(a)] = $urandom;
    return mem[int'(a)];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_addr = '0; m_inc = 1'b0; m_err = 1'b0; m_mon = '0; m_wdata = '0;
  endtask

  function automatic logic [37:0] load_jdo(input logic [15:0] a, input bit inc, input bit rd);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[15:0] = a;
    j[34] = inc;
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] write_jdo(input logic [31:0] d);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[34:3] = d;
    return j;
  endfunction

  // Issue one command set in IDLE, serve the bus like a slave, then check outcome
  task automatic op(input bit a, input bit na, input bit b, input logic [37:0] j,
                    input int waits, input int lat, input bit inject);
    bit          rd;
    bit          wr;
    int          c0;
    logic [15:0] ea;
    logic [31:0] rv;
    jdo = j;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    avm_waitrequest = (waits > 0);
    c0 = edges;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    wr = b;
    rd = !b && ((a && j[35]) || (!a && na));
    if (!b && a) begin
      m_addr = j[15:0];
      m_inc = j[34];
      m_err = 1'b0;
    end
    if (wr) m_wdata = j[34:3];
    ea = m_addr;
    last_hi = 0;
    if (rd || wr) begin
      check("ready_drop", monitor_ready, 1'b0);
      for (int i = 0; i <= waits; i++) begin
        avm_waitrequest = (i < waits);
        avm_readdatavalid = $urandom_range(0, 1);
        avm_readdata = $urandom;
        check("strobe", rd ? avm_read : avm_write, 1'b1);
        check("other_strobe", rd ? avm_write : avm_read, 1'b0);
        check("addr", avm_address, {ea, 2'b00});
        if (wr) check("wdata", avm_writedata, m_wdata);
        if (avm_read || avm_write) last_hi++;
        @(negedge clk);
      end
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      check("strobe_drop", avm_read | avm_write, 1'b0);
      if (rd) begin
        rv = mem_rd(ea);
        for (int l = 0; l < lat; l++) begin
          if (inject && l == 0) begin
            take_action_ocimem_b = 1'b1;
            jdo = write_jdo($urandom);
          end
          avm_readdatavalid = (l == lat - 1);
          avm_readdata = (l == lat - 1) ? rv : $urandom;
          if (l != lat - 1) check("ready_wait", monitor_ready, 1'b0);
          @(negedge clk);
          take_action_ocimem_b = 1'b0;
        end
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (inject) m_err = 1'b1;
        m_mon = rv;
      end else begin
        mem[int'(ea)] = m_wdata;
      end
      if (m_inc) m_addr = m_addr + 16'd1;
    end
    last_lat = edges - c0;
    check("ready_done", monitor_ready, 1'b1);
    check("mondreg", MonDReg, m_mon);
    check("error", monitor_error, m_err);
    check("idle_strobes", {avm_read, avm_write}, 2'b00);
    check("idle_addr", avm_address, {m_addr, 2'b00});
  endtask

  initial begin
    int          kind;
    int          n;
    logic [15:0] ra;
    logic [37:0] j;

    do_reset();
    check("rst_ready", monitor_ready, 1'b1);
    check("rst_error", monitor_error, 1'b0);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_strobes", {avm_read, avm_write}, 2'b00);
    check("rst_addr", avm_address, 18'h0);
    check("rst_wdata", avm_writedata, 32'h0);

    // Load-and-read at 0x0010, zero wait, one-cycle latency
    mem[16'h0010] = 32'h12345678;
    op(1, 0, 0, load_jdo(16'h0010, 0, 1), 0, 1, 0);
    check("rd_latency", last_lat, 3);
    check("rd_data", MonDReg, 32'h12345678);
    op(0, 1, 0, 38'h0, 0, 1, 0);
    check("no_inc_addr", avm_address, 18'h00040);

    // Wrapping auto-increment on a stalled write
    op(1, 0, 0, load_jdo(16'hFFFF, 1, 0), 0, 1, 0);
    op(0, 0, 1, write_jdo(32'hA5A5A5A5), 4, 1, 0);
    check("wr_hold_cycles", last_hi, 5);
    check("wrap_addr", avm_address, 18'h0);

    // Write strobe during a read is dropped and flagged
    op(0, 1, 0, 38'h0, 1, 2, 1);
    check("busy_error", monitor_error, 1'b1);
    op(1, 0, 0, load_jdo(16'h0003, 0, 0), 0, 1, 0);
    check("error_cleared", monitor_error, 1'b0);

    // Write wins over a simultaneous read-at-current
    op(0, 1, 1, write_jdo(32'hCAFEF00D), 0, 1, 0);
    check("prio_mem", mem[3], 32'hCAFEF00D);

    // Randomized command mix
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = $urandom;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        check("stray_valid", MonDReg, m_mon);
      end
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      case (kind)
        0: j = load_jdo(ra, $urandom_range(0, 1), $urandom_range(0, 1));
        1: j = load_jdo(ra, 0, 0);
        2: j = write_jdo($urandom);
        default: j = ($urandom_range(0, 1) == 1) ? write_jdo($urandom) : load_jdo(ra, $urandom_range(0, 1), $urandom_range(0, 1));
      endcase
      op(kind == 0 || (kind == 3 && $urandom_range(0, 1) == 1),
         kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1),
         kind == 2 || (kind == 3 && j[35] == 1'b0 && $urandom_range(0, 1) == 1),
         j, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 7) == 0);
    end

    // Slave that never releases waitrequest
    jdo = load_jdo(16'h0022, 1, 1);
    take_action_ocimem_a = 1'b1;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    n = 0;
    while (avm_read && n < 20) begin
      n++;
      @(negedge clk);
    end
`ifdef NIOS_DBG_MEM_TIMEOUT_EN
    check("tmo_cycles", n, 8);
    check("tmo_mondreg", MonDReg, 32'hDEADDEAD);
    check("tmo_error", monitor_error, 1'b1);
    check("tmo_ready", monitor_ready, 1'b1);
    check("tmo_no_inc", avm_address, {16'h0022, 2'b00});
`else
    check("stuck_cycles", n, 20);
    check("stuck_ready", monitor_ready, 1'b0);
`endif

    // Reset in the middle of an access
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    check("midrst_strobes", {avm_read, avm_write}, 2'b00);
    check("midrst_ready", monitor_ready, 1'b1);
    check("midrst_error", monitor_error, 1'b0);
    check("midrst_mondreg", MonDReg, 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_quiet", {avm_read, monitor_ready}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
